// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier (MUL / UMULL / SMULL) for the multicycle ARM core.
// Optional early termination on a zero remaining multiplier: define MUL_EARLY_TERM_EN.
module mul_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             IsLongMul,
  input  logic             Signed,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUResult2
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             is_long;
  logic             neg;

  logic             signed_op_c;
  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;
  logic [PW-1:0]    acc_sum_c;
  logic [PW-1:0]    acc_fixed_c;
  logic             last_iter_c;

  // Signed mode only applies to long multiplies; magnitudes are multiplied unsigned.
  assign signed_op_c = IsLongMul & Signed;
  assign abs_a_c     = (signed_op_c && SrcA[WIDTH-1]) ? (~SrcA + WIDTH'(1)) : SrcA;
  assign abs_b_c     = (signed_op_c && SrcB[WIDTH-1]) ? (~SrcB + WIDTH'(1)) : SrcB;

  assign acc_sum_c   = mplier[0] ? (acc + mcand) : acc;
  assign acc_fixed_c = neg ? (~acc + PW'(1)) : acc;

`ifdef MUL_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after this iteration.
  assign last_iter_c = (cnt == CW'(1)) || ((mplier >> 1) == '0);
`else
  assign last_iter_c = (cnt == CW'(1));
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter_c) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      is_long    <= 1'b0;
      neg        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ALUResult  <= '0;
      ALUResult2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_long <= IsLongMul;
            neg     <= signed_op_c & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            mcand   <= PW'(abs_a_c);
            mplier  <= abs_b_c;
            acc     <= '0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
          end
        end
        CALC: begin
          acc    <= acc_sum_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
        end
        FIX: begin
          ALUResult  <= acc_fixed_c[WIDTH-1:0];
          ALUResult2 <= is_long ? acc_fixed_c[PW-1:WIDTH] : '0;
          done       <= 1'b1;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: randomized operations against a cycle-timed behavioural model.
// Honours MUL_EARLY_TERM_EN the same way the design does.
module tb_mul_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        IsLongMul;
  logic        Signed;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;
  logic [31:0] ALUResult2;

  mul_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .IsLongMul  (IsLongMul),
    .Signed     (Signed),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .busy       (busy),
    .done       (done),
    .ALUResult  (ALUResult),
    .ALUResult2 (ALUResult2)
  );

  typedef struct {
    int          acc;
    int          n;
    logic [31:0] lo;
    logic [31:0] hi;
  } op_t;

  op_t q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  done_cyc = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cyc = cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Expected product from plain integer arithmetic.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic lng, input logic sg);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    if (lng && sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return 64'(ua * ub);
  endfunction

  function automatic int exp_iters(input logic [31:0] b, input logic lng, input logic sg);
`ifdef MUL_EARLY_TERM_EN
    logic [31:0] m;
    int          n;
    m = (lng && sg && b[31]) ? (~b + 32'd1) : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n;
`else
    return 32;
`endif
  endfunction

  function automatic op_t make_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic lng, input logic sg, input int acc);
    op_t         op;
    logic [63:0] p;
    p      = ref_prod(a, b, lng, sg);
    op.acc = acc;
    op.n   = exp_iters(b, lng, sg);
    op.lo  = p[31:0];
    op.hi  = lng ? p[63:32] : 32'd0;
    return op;
  endfunction

  // Compare process: busy/done every cycle, results on the expected done cycle.
  int  d;
  logic exp_busy;
  logic exp_done;
  always @(negedge clk) begin
    if (!reset) begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      d        = 0;
      if (q.size() != 0 && cyc >= q[0].acc) begin
        d        = cyc - q[0].acc;
        exp_busy = (d <= q[0].n + 1);
        exp_done = (d == q[0].n + 1);
      end
      check("busy", 64'(busy), 64'(exp_busy));
      check("done", 64'(done), 64'(exp_done));
      if (exp_done) begin
        check("result_lo", 64'(ALUResult), 64'(q[0].lo));
        check("result_hi", 64'(ALUResult2), 64'(q[0].hi));
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic lng, input logic sg, output int acc);
    @(negedge clk);
    start = 1'b1; SrcA = a; SrcB = b; IsLongMul = lng; Signed = sg;
    @(posedge clk); #1;
    start = 1'b0;
    acc = cyc;
    q.push_back(make_op(a, b, lng, sg, acc));
    SrcA = $urandom(); SrcB = $urandom(); IsLongMul = 1'($urandom()); Signed = 1'($urandom());
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && q.size() != 0; k++) @(posedge clk);
    check("drain", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          acc;
    int          acc1;
    int          acc2;
    op_t         op1;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rl;
    logic        rs;

    reset = 1'b1; start = 1'b0; IsLongMul = 1'b0; Signed = 1'b0; SrcA = '0; SrcB = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_lo", 64'(ALUResult), 64'd0);
    check("reset_hi", 64'(ALUResult2), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Directed cases with hand-computed results
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, acc); wait_idle();
    check("umull_lo", 64'(ALUResult), 64'h0000_0001);
    check("umull_hi", 64'(ALUResult2), 64'hFFFF_FFFE);
`ifndef MUL_EARLY_TERM_EN
    check("umull_latency", 64'(done_cyc - acc), 64'd33);
`endif
    issue(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1, acc); wait_idle();
    check("smull_lo", 64'(ALUResult), 64'hFFFF_FFFA);
    check("smull_hi", 64'(ALUResult2), 64'hFFFF_FFFF);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, acc); wait_idle();
    check("smull_min_lo", 64'(ALUResult), 64'h0);
    check("smull_min_hi", 64'(ALUResult2), 64'h4000_0000);
    issue(32'd7, 32'd6, 1'b0, 1'b1, acc); wait_idle();
    check("mul_lo", 64'(ALUResult), 64'h2A);
    check("mul_hi", 64'(ALUResult2), 64'h0);
    issue(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, acc); wait_idle();
    check("mul_neg_lo", 64'(ALUResult), 64'hFFFF_FFFE);
    check("mul_neg_hi", 64'(ALUResult2), 64'h0);

`ifdef MUL_EARLY_TERM_EN
    issue(32'h1234_5678, 32'd1, 1'b1, 1'b0, acc); wait_idle();
    check("early_lo", 64'(ALUResult), 64'h1234_5678);
    check("early_latency", 64'(done_cyc - acc), 64'd2);
    issue(32'h1234_5678, 32'h8000_0000, 1'b1, 1'b0, acc); wait_idle();
    check("early_full_latency", 64'(done_cyc - acc), 64'd33);
`endif

    // start held high; operands change mid-CALC and are taken by the second accept
    @(negedge clk);
    start = 1'b1; SrcA = 32'd1000; SrcB = 32'd3000; IsLongMul = 1'b1; Signed = 1'b0;
    @(posedge clk); #1;
    acc1 = cyc;
    op1  = make_op(32'd1000, 32'd3000, 1'b1, 1'b0, acc1);
    q.push_back(op1);
    repeat (3) @(posedge clk); #1;
    SrcA = 32'hFFFF_FFF9; SrcB = 32'd11; IsLongMul = 1'b1; Signed = 1'b1;
    acc2 = acc1 + op1.n + 3;
    q.push_back(make_op(32'hFFFF_FFF9, 32'd11, 1'b1, 1'b1, acc2));
    for (int k = 0; k < 200 && cyc < acc2; k++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle();
    check("hold_lo", 64'(ALUResult), 64'hFFFF_FFB3);
    check("hold_hi", 64'(ALUResult2), 64'hFFFF_FFFF);
    repeat (4) @(posedge clk);

    // Reset in the middle of CALC
    issue(32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 1'b0, acc);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_lo", 64'(ALUResult), 64'd0);
    check("midreset_hi", 64'(ALUResult2), 64'd0);
    @(negedge clk) reset = 1'b0;
    issue(32'd5, 32'd5, 1'b1, 1'b0, acc); wait_idle();
    check("post_reset_lo", 64'(ALUResult), 64'd25);
    check("post_reset_hi", 64'(ALUResult2), 64'd0);

    // Randomized operations, some with ignored start pulses while busy
    for (int i = 0; i < 60; i++) begin
      ra = pick(); rb = pick(); rl = 1'($urandom()); rs = 1'($urandom());
      issue(ra, rb, rl, rs, acc);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        start = 1'b1; SrcA = $urandom(); SrcB = $urandom();
        @(negedge clk);
        start = 1'b0;
      end
      wait_idle();
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
